// File: rtl/tlul_host_adapter.sv
// Single-outstanding TL-UL host adapter: turns one simple request into one A beat,
// waits for the matching D beat and reports the result as a one-cycle response pulse.
module tlul_host_adapter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int IDW        = 8,
  parameter int TimeoutCyc = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // simple request/response port
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [AW-1:0]     req_addr_i,
  input  logic [DW-1:0]     req_wdata_i,
  input  logic [IDW-1:0]    req_id_i,
  output logic              rsp_valid_o,
  output logic [DW-1:0]     rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [IDW-1:0]    rsp_id_o,
  // TL-UL A channel
  output logic              a_valid_o,
  output logic [2:0]        a_opcode_o,
  output logic [2:0]        a_param_o,
  output logic [1:0]        a_size_o,
  output logic [IDW-1:0]    a_source_o,
  output logic [AW-1:0]     a_address_o,
  output logic [DW/8-1:0]   a_mask_o,
  output logic [DW-1:0]     a_data_o,
  input  logic              a_ready_i,
  // TL-UL D channel
  input  logic              d_valid_i,
  input  logic [2:0]        d_opcode_i,
  input  logic [IDW-1:0]    d_source_i,
  input  logic [DW-1:0]     d_data_i,
  input  logic              d_error_i,
  output logic              d_ready_o,
  // FSM state for observation
  output logic [1:0]        dbg_state_o
);

  // Handshakes: a beat/response moves on a rising edge where valid and ready are both
  // high; valid never waits on ready, and payload is held stable while valid is high.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_A_REQ  = 2'd1,
    ST_D_WAIT = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int CW = $clog2(TimeoutCyc + 1);
  localparam logic [2:0] OpPutFull   = 3'd0;
  localparam logic [2:0] OpGet       = 3'd4;
  localparam logic [2:0] OpAccessAck = 3'd0;
  localparam logic [2:0] OpAckData   = 3'd1;

  state_e          state_q, state_d;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [IDW-1:0]  id_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic            rsp_err_q;
  logic [IDW-1:0]  rsp_id_q;

  logic            timeout;
  logic            d_bad;
  logic [2:0]      exp_d_opcode;

  assign timeout      = (cnt_q == CW'(TimeoutCyc - 1));
  assign exp_d_opcode = we_q ? OpAccessAck : OpAckData;
  assign d_bad        = d_error_i | (d_source_i != id_q) | (d_opcode_i != exp_d_opcode);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) state_d = ST_A_REQ;
      end
      ST_A_REQ: begin
        if (a_ready_i)    state_d = ST_D_WAIT;
        else if (timeout) state_d = ST_RESP;
      end
      ST_D_WAIT: begin
        if (d_valid_i || timeout) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == ST_IDLE && req_valid_i) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_we_i ? req_wdata_i : '0;
        id_q    <= req_id_i;
      end

      // The counter restarts on every state change, so each wait phase gets its own budget.
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q == ST_A_REQ || state_q == ST_D_WAIT) begin
        cnt_q <= cnt_q + CW'(1);
      end

      if (state_q == ST_D_WAIT && d_valid_i) begin
        rsp_rdata_q <= we_q ? '0 : d_data_i;
        rsp_err_q   <= d_bad;
        rsp_id_q    <= id_q;
      end else if ((state_q == ST_A_REQ && !a_ready_i && timeout) ||
                   (state_q == ST_D_WAIT && timeout)) begin
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b1;
        rsp_id_q    <= id_q;
      end
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign d_ready_o   = (state_q == ST_D_WAIT);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_id_o    = rsp_id_q;
  assign dbg_state_o = state_q;

  // A payload is driven only while the beat is offered, and reads zero otherwise.
  assign a_valid_o   = (state_q == ST_A_REQ);
  assign a_opcode_o  = a_valid_o ? (we_q ? OpPutFull : OpGet) : 3'd0;
  assign a_param_o   = 3'd0;
  assign a_size_o    = a_valid_o ? 2'd2 : 2'd0;
  assign a_source_o  = a_valid_o ? id_q : '0;
  assign a_address_o = a_valid_o ? addr_q : '0;
  assign a_mask_o    = a_valid_o ? '1 : '0;
  assign a_data_o    = a_valid_o ? wdata_q : '0;

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Bench for tlul_host_adapter: the bench acts as the TL-UL device and checks every
// A beat and response against values derived from the request and the device reply.
module tb_tlul_host_adapter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IDW = 8;
  localparam int TO = 1024;
  localparam int RW = DW + 1 + IDW;

  // clock/reset block
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            req_valid, req_ready, req_we;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [IDW-1:0]  req_id;
  logic            rsp_valid, rsp_err;
  logic [DW-1:0]   rsp_rdata;
  logic [IDW-1:0]  rsp_id;
  logic            a_valid, a_ready;
  logic [2:0]      a_opcode, a_param;
  logic [1:0]      a_size;
  logic [IDW-1:0]  a_source;
  logic [AW-1:0]   a_address;
  logic [DW/8-1:0] a_mask;
  logic [DW-1:0]   a_data;
  logic            d_valid, d_error, d_ready;
  logic [2:0]      d_opcode;
  logic [IDW-1:0]  d_source;
  logic [DW-1:0]   d_data;
  logic [1:0]      dbg_state;

  tlul_host_adapter #(.AW(AW), .DW(DW), .IDW(IDW), .TimeoutCyc(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_id_i(req_id),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .rsp_id_o(rsp_id),
    .a_valid_o(a_valid), .a_opcode_o(a_opcode), .a_param_o(a_param), .a_size_o(a_size),
    .a_source_o(a_source), .a_address_o(a_address), .a_mask_o(a_mask), .a_data_o(a_data),
    .a_ready_i(a_ready),
    .d_valid_i(d_valid), .d_opcode_i(d_opcode), .d_source_i(d_source), .d_data_i(d_data),
    .d_error_i(d_error), .d_ready_o(d_ready),
    .dbg_state_o(dbg_state)
  );

  logic [83:0]   a_obs;
  logic [RW-1:0] rsp_obs;
  assign a_obs   = {a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data};
  assign rsp_obs = {rsp_rdata, rsp_err, rsp_id};

  int total = 0;
  int bad = 0;
  int a_beats = 0;
  int rsp_pulses = 0;
  logic [RW-1:0] exp_q[$];

  always @(posedge clk) begin
    if (!rst && a_valid && a_ready) a_beats++;
    if (!rst && rsp_valid) rsp_pulses++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference A beat: what a full-word Put/Get for this request must look like.
  function automatic logic [83:0] a_ref(input logic we, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [7:0] id);
    return {(we ? 3'd0 : 3'd4), 3'd0, 2'd2, id, addr, 4'hF, (we ? wdata : 32'd0)};
  endfunction

  task automatic drive_idle();
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_id = '0;
    a_ready = 0; d_valid = 0; d_opcode = '0; d_source = '0; d_data = '0; d_error = 0;
  endtask

  // Present a request for one cycle, then scramble the request fields.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [7:0] id);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_id = id;
    @(negedge clk);
    req_valid = 0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_id = 8'($urandom);
    check("a_valid_latency", a_valid, 1);
    check("req_ready_busy", req_ready, 0);
  endtask

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [7:0] id, input int a_wait, input int d_wait,
                         input bit bad_src, input bit bad_op, input bit derr,
                         input logic [31:0] rdata);
    logic [83:0]   pay;
    logic [RW-1:0] e;
    int b0, p0;
    pay = a_ref(we, addr, wdata, id);
    exp_q.push_back({(we ? 32'd0 : rdata), (derr | bad_src | bad_op), id});
    b0 = a_beats; p0 = rsp_pulses;
    issue(we, addr, wdata, id);
    for (int k = 0; k < a_wait; k++) begin
      check("a_payload_hold", a_obs, pay);
      check("d_ready_in_a", d_ready, 0);
      a_ready = 0; d_valid = 1'($urandom_range(0, 1)); d_source = 8'($urandom);
      req_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("a_valid_hold", a_valid, 1);
    end
    check("a_payload", a_obs, pay);
    a_ready = 1; d_valid = 0;
    @(negedge clk);
    a_ready = 0;
    check("a_valid_drop", a_valid, 0);
    check("d_ready", d_ready, 1);
    for (int k = 0; k < d_wait; k++) begin
      d_valid = 0; req_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("d_wait_no_rsp", rsp_valid, 0);
      check("d_ready_hold", d_ready, 1);
    end
    d_valid = 1; d_source = bad_src ? (id ^ 8'h01) : id;
    d_opcode = (we ^ bad_op) ? 3'd0 : 3'd1; d_error = derr; d_data = rdata;
    @(negedge clk);
    d_valid = 0; d_error = 0; req_valid = 0;
    check("rsp_valid", rsp_valid, 1);
    check("sb_size", exp_q.size(), 1);
    e = exp_q.pop_front();
    check("rsp_fields", rsp_obs, e);
    @(negedge clk);
    check("rsp_one_cycle", rsp_valid, 0);
    check("rsp_hold", rsp_obs, e);
    check("a_beat_count", a_beats - b0, 1);
    check("rsp_pulse_count", rsp_pulses - p0, 1);
    check("req_ready_back", req_ready, 1);
  endtask

  // Never answer the A beat (in_d=0) or the D phase (in_d=1) and expect a timeout error.
  task automatic run_timeout(input bit in_d, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [7:0] id);
    logic [RW-1:0] e;
    int n, b0, p0;
    exp_q.push_back({32'd0, 1'b1, id});
    b0 = a_beats; p0 = rsp_pulses; n = 0;
    issue(we, addr, wdata, id);
    if (in_d) begin
      a_ready = 1;
      @(negedge clk);
      a_ready = 0;
      while (d_ready && n < TO + 8) begin n++; @(negedge clk); end
      check("d_timeout_cycles", n, TO);
    end else begin
      while (a_valid && n < TO + 8) begin n++; @(negedge clk); end
      check("a_timeout_cycles", n, TO);
    end
    check("to_rsp_valid", rsp_valid, 1);
    check("to_sb_size", exp_q.size(), 1);
    e = exp_q.pop_front();
    check("to_rsp_fields", rsp_obs, e);
    check("to_a_valid", a_valid, 0);
    check("to_d_ready", d_ready, 0);
    @(negedge clk);
    check("to_req_ready", req_ready, 1);
    check("to_a_beats", a_beats - b0, in_d ? 1 : 0);
    check("to_rsp_pulses", rsp_pulses - p0, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_a_valid"}, a_valid, 0);
    check({tag, "_d_ready"}, d_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_fields"}, rsp_obs, 0);
    check({tag, "_a_payload"}, a_obs, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    drive_idle();
    rst = 1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 0;
    @(negedge clk);

    run_txn(1, 32'h0, 32'h1, 8'd0, 0, 0, 0, 0, 0, 32'h0);
    run_txn(1, 32'h4, 32'hF, 8'd1, 0, 1, 0, 0, 0, 32'h1234_5678);
    run_txn(0, 32'h8, 32'hDEAD_BEEF, 8'd2, 0, 0, 0, 0, 0, 32'hA5A5_0003);
    run_txn(0, 32'h10, 32'h0, 8'd2, 5, 0, 0, 0, 0, 32'h0BAD_F00D);
    run_txn(0, 32'hC, 32'h0, 8'd2, 0, 0, 1, 0, 0, 32'h1111_2222);
    run_txn(1, 32'h14, 32'h5555_AAAA, 8'd7, 1, 2, 0, 0, 1, 32'h0);
    run_txn(0, 32'h18, 32'h0, 8'd9, 0, 0, 0, 1, 0, 32'h3333_4444);
    run_txn(0, 32'h1C, 32'h0, 8'd4, 0, 0, 0, 0, 0, 32'hCAFE_0001);

    // Reset while waiting for D: no response, everything back to reset values.
    p0 = rsp_pulses;
    issue(0, 32'h20, 32'h0, 8'd5);
    a_ready = 1;
    @(negedge clk);
    a_ready = 0;
    check("rst_in_d_wait", d_ready, 1);
    rst = 1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 0;
    @(negedge clk);
    check("midrst_no_rsp", rsp_valid, 0);
    check("midrst_pulses", rsp_pulses - p0, 0);

    run_txn(1, 32'h0000_0003, 32'h0102_0304, 8'hFE, 0, 0, 0, 0, 0, 32'h0);
    run_timeout(0, 1, 32'h40, 32'h7777_7777, 8'd3);
    run_timeout(1, 0, 32'h44, 32'h0, 8'd6);

    for (int i = 0; i < 30; i++) begin
      run_txn(1'($urandom), $urandom, $urandom, 8'($urandom), $urandom_range(0, 4),
              $urandom_range(0, 3), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) == 0), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
